// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   Receives one 10-bit word per slave-select frame ({cmd[1:0], payload[7:0]},
//   MSB first, one MOSI bit per clk) and hands it to the memory stage with a
//   one-cycle rx_valid strobe.
//   On a read-data command, the slave waits for the memory stage to return a
//   byte on tx_data/tx_valid and then shifts it out on MISO, MSB first.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   SS_n      slave select, active low; one word per low period
//   MOSI      serial data in
//   MISO      serial read data out (registered, 0 when not shifting)
//   rx_data   assembled word to the memory stage
//   rx_valid  one-cycle strobe qualifying rx_data
//   tx_data   read byte from the memory stage
//   tx_valid  strobe qualifying tx_data
// -----------------------------------------------------------------------------
module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  localparam logic [3:0] LAST_CNT = 4'd9;   // bits held before bit 0 arrives
  localparam logic [3:0] DONE_CNT = 4'd10;  // saturated: word complete
  localparam logic [3:0] TX_BITS  = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [8:0]  rx_shift;
  logic        rd_addr_flag;
  logic [7:0]  tx_shift;
  logic [3:0]  sh_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      rx_shift     <= 9'd0;
      rx_data      <= 10'd0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_shift     <= 8'd0;
      sh_cnt       <= 4'd0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // MISO shifter: sh_cnt counts the cycles the current byte still owns
      // MISO. Bit 7 is presented on the latch edge itself, so the last count
      // drives MISO back to 0.
      if (sh_cnt != 4'd0) begin
        sh_cnt   <= sh_cnt - 4'd1;
        MISO     <= (sh_cnt > 4'd1) ? tx_shift[7] : 1'b0;
        tx_shift <= {tx_shift[6:0], 1'b0};
      end else begin
        MISO <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          bit_cnt <= 4'd0;
          if (!SS_n) state <= CHK_CMD;
        end

        CHK_CMD: begin
          if (SS_n) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
          end else begin
            rx_shift <= {rx_shift[7:0], MOSI};
            bit_cnt  <= 4'd1;
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_flag) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt == LAST_CNT) begin
            // Bit 0 completes the word even if SS_n rises on this same edge.
            rx_data  <= {rx_shift, MOSI};
            rx_valid <= 1'b1;
            bit_cnt  <= DONE_CNT;
            if (state == READ_ADD)  rd_addr_flag <= 1'b1;
            if (state == READ_DATA) rd_addr_flag <= 1'b0;
            if (SS_n) begin
              state   <= IDLE;
              bit_cnt <= 4'd0;
            end
          end else if (SS_n) begin
            // Abort: drop the partial word and any byte in flight.
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            sh_cnt   <= 4'd0;
            tx_shift <= 8'd0;
            MISO     <= 1'b0;
          end else if (bit_cnt != DONE_CNT) begin
            rx_shift <= {rx_shift[7:0], MOSI};
            bit_cnt  <= bit_cnt + 4'd1;
          end else if (state == READ_DATA && tx_valid && sh_cnt == 4'd0) begin
            MISO     <= tx_data[7];
            tx_shift <= {tx_data[6:0], 1'b0};
            sh_cnt   <= TX_BITS;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 10 bits in and 8 bits out.
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 SS_n  input  1  SPI slave select, active low; one frame per low period.
REQ-005 MOSI  input  1  serial data in, MSB first, sampled every clk while SS_n=0.
REQ-006 MISO  output  1  serial read data out, MSB first; registered.
REQ-007 rx_data  output  10  assembled word {cmd[1:0], payload[7:0]} to the memory stage.
REQ-008 rx_valid  output  1  one-cycle strobe; rx_data is valid while it is high.
REQ-009 tx_data  input  8  read data returned by the memory stage.
REQ-010 tx_valid  input  1  strobe qualifying tx_data.

Function
REQ-011 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-012 IDLE: SS_n=0 -> CHK_CMD at the next edge; otherwise remain in IDLE.
REQ-013 CHK_CMD: sample MOSI as word bit 9 and shift it in; next state is WRITE if MOSI=0, READ_ADD if MOSI=1 and rd_addr_flag=0, and READ_DATA if MOSI=1 and rd_addr_flag=1.
REQ-014 WRITE, READ_ADD and READ_DATA: shift in bits 8..0 on the next 9 clocks, one bit per clk.
REQ-015 After bit 0 is sampled, rx_data SHALL hold the full word and rx_valid SHALL be 1 for exactly the following cycle.
REQ-016 Cycle timing: SS_n=0 sampled in cycle 0; bit 9 is sampled in cycle 1; bit 0 in cycle 10; rx_valid is high in cycle 11.
REQ-017 rx_data SHALL hold its value until the next completed word.
REQ-018 Only one word SHALL be accepted per frame; further MOSI bits are ignored until SS_n returns high.
REQ-019 rd_addr_flag SHALL be set when a READ_ADD word completes and cleared when a READ_DATA word completes; WRITE words leave it unchanged.
REQ-020 In READ_DATA, after rx_valid, tx_valid=1 SHALL latch tx_data into the output shift register.
REQ-021 MISO SHALL present latched bits 7..0 on the 8 cycles after the latch, one bit per cycle.
REQ-022 MISO SHALL be 0 at all times other than the 8 shift cycles of REQ-021.
REQ-023 tx_valid SHALL be ignored in any state other than READ_DATA-after-word-complete, and during an active MISO shift.
REQ-024 SS_n=1 in any non-IDLE state SHALL return the FSM to IDLE at the next edge, with the following effects:
- bit counter cleared;
- the partial word is discarded and no rx_valid is issued;
- any MISO shift is aborted and MISO=0;
- rd_addr_flag is unchanged.
REQ-025 If SS_n rises in the same cycle bit 0 is sampled, the word SHALL complete (rx_valid next cycle) and the FSM SHALL go to IDLE.
REQ-026 The 4-bit bit counter SHALL not wrap; it saturates at word-complete until IDLE.

Reset
REQ-027 rst=1 at a clk edge SHALL force the following values, overriding all other inputs including mid-frame activity:
- state=IDLE;
- rx_data=0, rx_valid=0, MISO=0;
- rd_addr_flag=0;
- bit and shift counters = 0;
- output shift register = 0.
REQ-028 The first frame after reset SHALL be accepted normally, starting with SS_n=0 in the cycle after rst deasserts.

Verification
REQ-029 Write address: SS_n=0 with MOSI 00_0101_0101 -> rx_valid high once in cycle 11 with rx_data=0x055; rd_addr_flag stays 0.
REQ-030 Write data: MOSI 01_1010_1010 -> rx_data=0x1AA with a single rx_valid; FSM goes to IDLE after SS_n=1.
REQ-031 Read sequence, in order:
- frame MOSI 10_0000_0011 -> rx_data=0x203 and rd_addr_flag=1;
- next frame MOSI 11_xxxx_xxxx -> rx_data[9:8]=11;
- tx_valid with tx_data=0xC5 one cycle after rx_valid -> MISO shows 1,1,0,0,0,1,0,1 on the next 8 cycles, then 0;
- rd_addr_flag=0 afterwards.
REQ-032 Abort: SS_n=1 after 6 bits of a write -> no rx_valid, FSM in IDLE next cycle, next full frame decodes correctly.
REQ-033 Reset mid-shift: rst=1 during the 4th MISO bit -> MISO=0, rx_valid=0 and FSM in IDLE next cycle; a subsequent READ_ADD frame is classified as READ_ADD.
REQ-034 Stray tx_valid pulse in IDLE or WRITE -> MISO stays 0, no state change.
